// File: rtl/nibble_tx.sv
// Purpose: serializes 32-bit words into LSB-first 4-bit beats; an all-zero word can collapse to one marker beat.
// Latency: the first beat appears the cycle after the input handshake; beats of back-to-back words follow with no bubble.
// Backpressure: NIB_READY low freezes the beat and the shift state; IN_READY opens only when idle or on the last beat's handshake.
module nibble_tx #(
    parameter int ZERO_COMPRESS = 1,
    parameter int NIB_W         = 4,
    parameter int WORD_W        = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [WORD_W-1:0] IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [NIB_W-1:0]  NIB_OUT,
    output logic              NIB_VALID,
    output logic              NIB_LAST,
    output logic              NIB_ZERO,
    input  logic              NIB_READY,
    output logic              BUSY
);
    localparam int BEATS = WORD_W / NIB_W;

    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, ZSEND = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [NIB_W-1:0]    nib_out_q, nib_out_d;
    logic                nib_valid_q, nib_valid_d;
    logic                nib_last_q, nib_last_d;
    logic                nib_zero_q, nib_zero_d;

    logic in_hs;
    logic beat;
    logic in_is_zero;

    assign IN_READY   = (state_q == IDLE) | (nib_valid_q & NIB_READY & nib_last_q);
    assign in_hs      = IN_VALID & IN_READY;
    assign beat       = nib_valid_q & NIB_READY;
    assign in_is_zero = (ZERO_COMPRESS != 0) && (IN_DATA == '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            nib_out_q   <= '0;
            nib_valid_q <= 1'b0;
            nib_last_q  <= 1'b0;
            nib_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            nib_out_q   <= nib_out_d;
            nib_valid_q <= nib_valid_d;
            nib_last_q  <= nib_last_d;
            nib_zero_q  <= nib_zero_d;
        end
    end

    // A word may be loaded from IDLE or on the closing beat of the previous word.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_hs) begin
                    if (in_is_zero) begin
                        state_d = ZSEND;
                    end else begin
                        state_d = SEND;
                        shift_d = IN_DATA;
                        cnt_d   = '0;
                    end
                end
            end
            SEND: begin
                if (beat) begin
                    if (cnt_q == 3'(BEATS - 1)) begin
                        if (in_hs && in_is_zero) begin
                            state_d = ZSEND;
                        end else if (in_hs) begin
                            state_d = SEND;
                            shift_d = IN_DATA;
                            cnt_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        shift_d = shift_q >> NIB_W;
                        cnt_d   = cnt_q + 3'd1;
                    end
                end
            end
            ZSEND: begin
                if (beat) begin
                    if (in_hs && in_is_zero) begin
                        state_d = ZSEND;
                    end else if (in_hs) begin
                        state_d = SEND;
                        shift_d = IN_DATA;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output flops are loaded from the next state, so a stalled beat recomputes identical values.
    always_comb begin
        nib_valid_d = (state_d != IDLE);
        nib_out_d   = '0;
        nib_last_d  = 1'b0;
        nib_zero_d  = 1'b0;
        if (state_d == SEND) begin
            nib_out_d  = shift_d[NIB_W-1:0];
            nib_last_d = (cnt_d == 3'(BEATS - 1));
        end else if (state_d == ZSEND) begin
            nib_last_d = 1'b1;
            nib_zero_d = 1'b1;
        end
    end

    assign NIB_OUT   = nib_out_q;
    assign NIB_VALID = nib_valid_q;
    assign NIB_LAST  = nib_last_q;
    assign NIB_ZERO  = nib_zero_q;
    assign BUSY      = (state_q != IDLE);

endmodule
